gate_actuator_responder: RTL and testbench

Gate-side responder for the parking controller's gate handshake. Consumes the controller's `open_gate`, `close_gate` and `blocked_gate` commands, drives the barrier motor through a timed travel model, and returns a one-cycle `gate_ack` when a commanded motion completes. It sits between the parking controller and the physical barrier, and is also the gate model instantiated by the tester in place of the hand-driven `gate_ack`.

---
 rtl/parking_pkg.sv | 21 ++
 rtl/gate_position_counter.sv | 31 +++
 rtl/gate_actuator_responder.sv | 149 ++++++++++++++
 tb/tb_gate_actuator_responder.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared parking-controller definitions: gate FSM encoding and barrier position width.
package parking_pkg;

  localparam int GATE_POS_W = 8;

  typedef enum logic [2:0] {
    GS_CLOSED  = 3'd0,
    GS_OPENING = 3'd1,
    GS_OPEN    = 3'd2,
    GS_CLOSING = 3'd3,
    GS_LOCKED  = 3'd4
  } gate_state_e;

  // Plain constants for code that keeps the state in a logic vector.
  localparam logic [2:0] ST_CLOSED  = 3'd0;
  localparam logic [2:0] ST_OPENING = 3'd1;
  localparam logic [2:0] ST_OPEN    = 3'd2;
  localparam logic [2:0] ST_CLOSING = 3'd3;
  localparam logic [2:0] ST_LOCKED  = 3'd4;

endpackage

// File: rtl/gate_position_counter.sv
// Saturating up/down counter that tracks barrier position between 0 and MAX_VAL.
module gate_position_counter #(
  parameter int           W       = 8,
  parameter logic [W-1:0] MAX_VAL = W'(8)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] pos,
  output logic         at_min,
  output logic         at_max
);

  logic [W-1:0] pos_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos_reg <= '0;
    end else if (inc && !at_max) begin
      pos_reg <= pos_reg + W'(1);
    end else if (dec && !at_min) begin
      pos_reg <= pos_reg - W'(1);
    end
  end

  assign pos    = pos_reg;
  assign at_min = (pos_reg == '0);
  assign at_max = (pos_reg >= MAX_VAL);

endmodule

// File: rtl/gate_actuator_responder.sv
// Gate-side responder: turns open/close/blocked command levels into timed barrier motion and a one-cycle ack.
// Define GATE_OBSTRUCTION_EN to let the beam sensor reverse or inhibit closing.
module gate_actuator_responder
  import parking_pkg::*;
#(
  parameter int TRAVEL_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  open_gate,
  input  logic                  close_gate,
  input  logic                  blocked_gate,
  input  logic                  obstruction,
  output logic                  gate_ack,
  output logic                  motor_up,
  output logic                  motor_down,
  output logic                  gate_is_open,
  output logic [GATE_POS_W-1:0] gate_pos
);

  localparam logic [GATE_POS_W-1:0] POS_MAX  = GATE_POS_W'(TRAVEL_CYCLES);
  localparam logic [GATE_POS_W-1:0] POS_LAST = GATE_POS_W'(TRAVEL_CYCLES - 1);

  logic [2:0] state_reg, state_next;
  logic       open_armed_reg, open_armed_next;
  logic       close_armed_reg, close_armed_next;
  logic       pending_reg, pending_next;
  logic       ack_reg, ack_next;
  logic       clr_open, clr_close;
  logic       open_req, close_req, close_inhibit;
  logic       at_min, at_max, open_done, close_done;

  gate_position_counter #(
    .W       (GATE_POS_W),
    .MAX_VAL (POS_MAX)
  ) u_pos (
    .clk    (clk),
    .rst    (rst),
    .inc    (state_reg == ST_OPENING),
    .dec    ((state_reg == ST_CLOSING) || (state_reg == ST_LOCKED)),
    .pos    (gate_pos),
    .at_min (at_min),
    .at_max (at_max)
  );

  // Travel ends on the edge that makes the final step, so the motor runs exactly TRAVEL_CYCLES cycles.
  assign open_done  = at_max || (gate_pos == POS_LAST);
  assign close_done = at_min || (gate_pos == GATE_POS_W'(1));

`ifdef GATE_OBSTRUCTION_EN
  assign close_inhibit = obstruction;
`else
  logic unused_obstruction;
  assign unused_obstruction = obstruction;
  assign close_inhibit      = 1'b0;
`endif

  assign open_req  = open_gate && open_armed_reg;
  assign close_req = close_gate && close_armed_reg && !close_inhibit;

  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    ack_next     = 1'b0;
    clr_open     = 1'b0;
    clr_close    = 1'b0;
    if (blocked_gate) begin
      state_next   = ST_LOCKED;
      pending_next = 1'b0;
    end else begin
      case (state_reg)
        ST_CLOSED: begin
          if (open_req) begin
            state_next   = ST_OPENING;
            pending_next = 1'b1;
          end else if (close_req) begin
            ack_next  = 1'b1;
            clr_close = 1'b1;
          end
        end
        ST_OPEN: begin
          if (close_req) begin
            state_next   = ST_CLOSING;
            pending_next = 1'b1;
          end else if (open_req) begin
            ack_next = 1'b1;
            clr_open = 1'b1;
          end
        end
        ST_OPENING: begin
          if (open_done) begin
            state_next   = ST_OPEN;
            pending_next = 1'b0;
            ack_next     = pending_reg;
            clr_open     = pending_reg;
          end
        end
        ST_CLOSING: begin
`ifdef GATE_OBSTRUCTION_EN
          if (obstruction) begin
            // Reversal is not a commanded open: no ack, and close stays armed for a retry.
            state_next   = ST_OPENING;
            pending_next = 1'b0;
          end else
`endif
          if (close_done) begin
            state_next   = ST_CLOSED;
            pending_next = 1'b0;
            ack_next     = pending_reg;
            clr_close    = pending_reg;
          end
        end
        ST_LOCKED: begin
          state_next = at_min ? ST_CLOSED : ST_CLOSING;
        end
        default: begin
          state_next   = ST_CLOSED;
          pending_next = 1'b0;
        end
      endcase
    end
  end

  // A flag re-arms whenever its command is seen low; clearing only bites while the command is still held.
  assign open_armed_next  = !open_gate  || (open_armed_reg  && !clr_open);
  assign close_armed_next = !close_gate || (close_armed_reg && !clr_close);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= ST_CLOSED;
      open_armed_reg  <= 1'b0;
      close_armed_reg <= 1'b0;
      pending_reg     <= 1'b0;
      ack_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      open_armed_reg  <= open_armed_next;
      close_armed_reg <= close_armed_next;
      pending_reg     <= pending_next;
      ack_reg         <= ack_next;
    end
  end

  assign gate_ack     = ack_reg;
  assign motor_up     = (state_reg == ST_OPENING);
  assign motor_down   = (state_reg == ST_CLOSING) || ((state_reg == ST_LOCKED) && !at_min);
  assign gate_is_open = (state_reg == ST_OPEN);

endmodule

// File: tb/tb_gate_actuator_responder.sv
// Self-checking bench for gate_actuator_responder: expected ack edges are queued and matched by a monitor.
module tb_gate_actuator_responder;

  localparam int TRAVEL = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       open_gate = 1'b0;
  logic       close_gate = 1'b0;
  logic       blocked_gate = 1'b0;
  logic       obstruction = 1'b0;
  logic       gate_ack, motor_up, motor_down, gate_is_open;
  logic [7:0] gate_pos;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;
  int exp_q[$];

  gate_actuator_responder #(.TRAVEL_CYCLES(TRAVEL)) dut (
    .clk          (clk),
    .rst          (rst),
    .open_gate    (open_gate),
    .close_gate   (close_gate),
    .blocked_gate (blocked_gate),
    .obstruction  (obstruction),
    .gate_ack     (gate_ack),
    .motor_up     (motor_up),
    .motor_down   (motor_down),
    .gate_is_open (gate_is_open),
    .gate_pos     (gate_pos)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  // Scoreboard: every ack must match the oldest queued edge; a queued edge that passes unanswered fails.
  always @(negedge clk) begin : monitor
    int e;
    if (rst) begin
      if (gate_ack) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL ack_unexpected: gate_ack=1 at edge %0d, required 0", edge_n);
        end else begin
          e = exp_q.pop_front();
          if (e != edge_n) begin
            n_fail++;
            $display("FAIL ack_edge: ack at edge %0d, required edge %0d", edge_n, e);
          end else begin
            $display("ack at edge %0d as expected", edge_n);
          end
        end
      end else if (exp_q.size() != 0 && exp_q[0] <= edge_n) begin
        n_checks++;
        n_fail++;
        $display("FAIL ack_missing: gate_ack=0 at edge %0d, required 1", edge_n);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_open();
    open_gate = 1'b1;
    exp_q.push_back(edge_n + 1 + TRAVEL);
    tick(TRAVEL + 1);
    n_checks++;
    if (gate_is_open !== 1'b1 || gate_pos !== 8'(TRAVEL)) begin
      n_fail++;
      $display("FAIL open_setup: is_open=%b pos=%0d, required 1 and %0d", gate_is_open, gate_pos, TRAVEL);
    end
    open_gate = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(3);
    n_checks++;
    if ({gate_ack, motor_up, motor_down, gate_is_open} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, required 0000", {gate_ack, motor_up, motor_down, gate_is_open});
    end
    n_checks++;
    if (gate_pos !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_pos: got %0d, required 0", gate_pos);
    end
    rst = 1'b1;
    tick(2);
    n_checks++;
    if ({motor_up, motor_down, gate_is_open} !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %b, required 000", {motor_up, motor_down, gate_is_open});
    end
    $display("reset done");
  endtask

  task automatic test_open();
    open_gate = 1'b1;
    exp_q.push_back(edge_n + 1 + TRAVEL);
    for (int i = 0; i < TRAVEL; i++) begin
      tick(1);
      n_checks++;
      if (motor_up !== 1'b1 || gate_pos !== 8'(i) || gate_is_open !== 1'b0) begin
        n_fail++;
        $display("FAIL open_travel[%0d]: up=%b pos=%0d open=%b, required 1 %0d 0", i, motor_up, gate_pos, gate_is_open, i);
      end
    end
    tick(1);
    n_checks++;
    if (gate_is_open !== 1'b1 || motor_up !== 1'b0 || gate_pos !== 8'(TRAVEL)) begin
      n_fail++;
      $display("FAIL open_done: open=%b up=%b pos=%0d, required 1 0 %0d", gate_is_open, motor_up, gate_pos, TRAVEL);
    end
    tick(4);
    n_checks++;
    if (gate_ack !== 1'b0 || gate_is_open !== 1'b1) begin
      n_fail++;
      $display("FAIL open_held: ack=%b open=%b, required 0 1", gate_ack, gate_is_open);
    end
    open_gate = 1'b0;
    tick(1);
    $display("open transaction done");
  endtask

  task automatic test_close();
    close_gate = 1'b1;
    exp_q.push_back(edge_n + 1 + TRAVEL);
    for (int i = 0; i < TRAVEL; i++) begin
      tick(1);
      n_checks++;
      if (motor_down !== 1'b1 || gate_pos !== 8'(TRAVEL - i)) begin
        n_fail++;
        $display("FAIL close_travel[%0d]: down=%b pos=%0d, required 1 %0d", i, motor_down, gate_pos, TRAVEL - i);
      end
    end
    tick(1);
    n_checks++;
    if (motor_down !== 1'b0 || gate_pos !== 8'd0 || gate_is_open !== 1'b0) begin
      n_fail++;
      $display("FAIL close_done: down=%b pos=%0d open=%b, required 0 0 0", motor_down, gate_pos, gate_is_open);
    end
    tick(3);
    close_gate = 1'b0;
    tick(1);
    // Re-raise while already closed: no-op ack on the following cycle.
    close_gate = 1'b1;
    exp_q.push_back(edge_n + 1);
    tick(1);
    n_checks++;
    if (gate_ack !== 1'b1 || motor_down !== 1'b0) begin
      n_fail++;
      $display("FAIL close_noop: ack=%b down=%b, required 1 0", gate_ack, motor_down);
    end
    tick(2);
    close_gate = 1'b0;
    tick(1);
    $display("close transaction done");
  endtask

  task automatic test_both();
    int a;
    open_gate  = 1'b1;
    close_gate = 1'b1;
    a = edge_n + 1 + TRAVEL;
    exp_q.push_back(a);
    exp_q.push_back(a + 1 + TRAVEL);
    tick(1);
    n_checks++;
    if (motor_up !== 1'b1 || motor_down !== 1'b0) begin
      n_fail++;
      $display("FAIL both_priority: up=%b down=%b, required 1 0", motor_up, motor_down);
    end
    tick(TRAVEL);
    n_checks++;
    if (gate_is_open !== 1'b1) begin
      n_fail++;
      $display("FAIL both_opened: open=%b, required 1", gate_is_open);
    end
    tick(1);
    n_checks++;
    if (motor_down !== 1'b1) begin
      n_fail++;
      $display("FAIL both_close_follows: down=%b, required 1", motor_down);
    end
    tick(TRAVEL + 1);
    n_checks++;
    if (gate_pos !== 8'd0 || motor_up !== 1'b0 || motor_down !== 1'b0) begin
      n_fail++;
      $display("FAIL both_final: pos=%0d up=%b down=%b, required 0 0 0", gate_pos, motor_up, motor_down);
    end
    open_gate  = 1'b0;
    close_gate = 1'b0;
    tick(2);
    $display("simultaneous open/close transaction done");
  endtask

  task automatic test_blocked();
    int md_cycles;
    open_gate = 1'b1;
    for (int i = 0; i < 20 && gate_pos !== 8'd3; i++) tick(1);
    n_checks++;
    if (gate_pos !== 8'd3) begin
      n_fail++;
      $display("FAIL blocked_setup: pos=%0d, required 3", gate_pos);
    end
    blocked_gate = 1'b1;
    tick(1);
    n_checks++;
    if (motor_down !== 1'b1 || motor_up !== 1'b0 || gate_pos !== 8'd4) begin
      n_fail++;
      $display("FAIL blocked_enter: down=%b up=%b pos=%0d, required 1 0 4", motor_down, motor_up, gate_pos);
    end
    md_cycles = 0;
    for (int i = 0; i < 20 && motor_down === 1'b1; i++) begin
      md_cycles++;
      tick(1);
    end
    n_checks++;
    if (md_cycles != 4 || gate_pos !== 8'd0) begin
      n_fail++;
      $display("FAIL blocked_drive: down cycles=%0d pos=%0d, required 4 0", md_cycles, gate_pos);
    end
    tick(3);
    n_checks++;
    if (motor_up !== 1'b0 || gate_is_open !== 1'b0) begin
      n_fail++;
      $display("FAIL blocked_ignore_open: up=%b open=%b, required 0 0", motor_up, gate_is_open);
    end
    open_gate = 1'b0;
    tick(2);
    blocked_gate = 1'b0;
    tick(1);
    n_checks++;
    if ({motor_up, motor_down, gate_is_open} !== 3'b000 || gate_pos !== 8'd0) begin
      n_fail++;
      $display("FAIL blocked_release: flags=%b pos=%0d, required 000 0", {motor_up, motor_down, gate_is_open}, gate_pos);
    end
    tick(2);
    $display("blocked transaction done");
  endtask

`ifdef GATE_OBSTRUCTION_EN
  task automatic test_obstruction();
    do_open();
    close_gate = 1'b1;
    for (int i = 0; i < 20 && gate_pos !== 8'd6; i++) tick(1);
    obstruction = 1'b1;
    tick(1);
    n_checks++;
    if (motor_up !== 1'b1 || gate_pos !== 8'd5) begin
      n_fail++;
      $display("FAIL obstruct_reverse: up=%b pos=%0d, required 1 5", motor_up, gate_pos);
    end
    obstruction = 1'b0;
    tick(2);
    n_checks++;
    if (motor_up !== 1'b1 || gate_pos !== 8'd7) begin
      n_fail++;
      $display("FAIL obstruct_reopen: up=%b pos=%0d, required 1 7", motor_up, gate_pos);
    end
    tick(1);
    n_checks++;
    if (gate_is_open !== 1'b1 || gate_pos !== 8'(TRAVEL)) begin
      n_fail++;
      $display("FAIL obstruct_open: open=%b pos=%0d, required 1 %0d", gate_is_open, gate_pos, TRAVEL);
    end
    exp_q.push_back(edge_n + 1 + TRAVEL);
    tick(1);
    n_checks++;
    if (motor_down !== 1'b1) begin
      n_fail++;
      $display("FAIL obstruct_retry: down=%b, required 1", motor_down);
    end
    tick(TRAVEL);
    n_checks++;
    if (gate_pos !== 8'd0 || motor_down !== 1'b0) begin
      n_fail++;
      $display("FAIL obstruct_closed: pos=%0d down=%b, required 0 0", gate_pos, motor_down);
    end
    close_gate = 1'b0;
    tick(1);
    $display("obstruction transaction done");
  endtask
`else
  task automatic test_obstruction();
    do_open();
    close_gate = 1'b1;
    exp_q.push_back(edge_n + 1 + TRAVEL);
    tick(3);
    obstruction = 1'b1;
    tick(2);
    n_checks++;
    if (motor_down !== 1'b1 || motor_up !== 1'b0) begin
      n_fail++;
      $display("FAIL obstruct_ignored: down=%b up=%b, required 1 0", motor_down, motor_up);
    end
    obstruction = 1'b0;
    tick(TRAVEL - 4);
    n_checks++;
    if (gate_pos !== 8'd0 || motor_down !== 1'b0) begin
      n_fail++;
      $display("FAIL obstruct_closed: pos=%0d down=%b, required 0 0", gate_pos, motor_down);
    end
    close_gate = 1'b0;
    tick(1);
    $display("obstruction transaction done");
  endtask
`endif

  task automatic test_reset_mid();
    do_open();
    close_gate = 1'b1;
    tick(4);
    n_checks++;
    if (motor_down !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_setup: down=%b, required 1", motor_down);
    end
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({gate_ack, motor_up, motor_down, gate_is_open} !== 4'b0000 || gate_pos !== 8'd0) begin
      n_fail++;
      $display("FAIL midreset_async: flags=%b pos=%0d, required 0000 0",
               {gate_ack, motor_up, motor_down, gate_is_open}, gate_pos);
    end
    tick(2);
    close_gate = 1'b0;
    rst = 1'b1;
    tick(3);
    n_checks++;
    if ({motor_up, motor_down, gate_is_open} !== 3'b000 || gate_pos !== 8'd0) begin
      n_fail++;
      $display("FAIL midreset_after: flags=%b pos=%0d, required 000 0", {motor_up, motor_down, gate_is_open}, gate_pos);
    end
    $display("mid-travel reset transaction done");
  endtask

  initial begin
    test_reset();
    test_open();
    test_close();
    test_both();
    test_blocked();
    test_obstruction();
    test_reset_mid();
    tick(3);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL ack_drain: %0d acks outstanding, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
